// File: rtl/mmio_bridge.sv
// Data-side bus stage behind the core: decodes word loads and stores onto data memory,
// LED/switch I/O registers and a prescaled down-counting timer with a level interrupt.
module mmio_bridge #(
    parameter int unsigned DM_AWIDTH = 10,
    parameter int unsigned PRESCALE  = 4,
    parameter logic [31:0] IO_BASE   = 32'h0000_7F00
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_we,
    input  logic [31:0]          addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic                 dm_we,
    output logic [DM_AWIDTH-1:0] dm_addr,
    output logic [31:0]          dm_wdata,
    input  logic [31:0]          dm_rdata,
    input  logic [15:0]          sw_in,
    output logic [15:0]          led_out,
    output logic                 irq
);

    localparam int unsigned      PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);
    localparam logic [32:0]      DM_LIMIT = 33'(4) << DM_AWIDTH;

    localparam logic [2:0] OFF_LED    = 3'd0;
    localparam logic [2:0] OFF_SW     = 3'd1;
    localparam logic [2:0] OFF_CTRL   = 3'd4;
    localparam logic [2:0] OFF_COUNT  = 3'd5;
    localparam logic [2:0] OFF_PRESET = 3'd6;
    localparam logic [2:0] OFF_STATUS = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CNT,
        ST_EXPIRE
    } timer_state_t;

    timer_state_t     state_q;
    timer_state_t     state_d;
    logic [15:0]      led_q;
    logic [15:0]      sw_meta_q;
    logic [15:0]      sw_sync_q;
    logic [2:0]       ctrl_q;
    logic [2:0]       ctrl_d;
    logic [31:0]      count_q;
    logic [31:0]      count_d;
    logic [31:0]      preset_q;
    logic             status_q;
    logic             status_d;
    logic [PSC_W-1:0] psc_q;
    logic [PSC_W-1:0] psc_d;
    logic             irq_q;

    logic       dm_hit;
    logic       io_hit;
    logic       io_sel;
    logic [2:0] io_off;
    logic       io_we;
    logic       wr_led;
    logic       wr_ctrl;
    logic       wr_count;
    logic       wr_preset;
    logic       wr_status;
    logic       expire_set;

    // Address decode; data memory takes priority should the windows ever overlap
    assign dm_hit = {1'b0, addr} < DM_LIMIT;
    assign io_hit = addr[31:5] == IO_BASE[31:5];
    assign io_sel = io_hit & ~dm_hit;
    assign io_off = addr[4:2];
    assign io_we  = mem_we & io_sel;

    assign wr_led    = io_we & (io_off == OFF_LED);
    assign wr_ctrl   = io_we & (io_off == OFF_CTRL);
    assign wr_count  = io_we & (io_off == OFF_COUNT);
    assign wr_preset = io_we & (io_off == OFF_PRESET);
    assign wr_status = io_we & (io_off == OFF_STATUS);

    assign dm_we    = mem_we & dm_hit;
    assign dm_addr  = addr[DM_AWIDTH+1:2];
    assign dm_wdata = wdata;

    assign led_out = led_q;
    assign irq     = irq_q;

    // Zero-latency load mux
    always_comb begin
        rdata = 32'd0;
        if (dm_hit) begin
            rdata = dm_rdata;
        end else if (io_sel) begin
            case (io_off)
                OFF_LED:    rdata = {16'd0, led_q};
                OFF_SW:     rdata = {16'd0, sw_sync_q};
                OFF_CTRL:   rdata = {29'd0, ctrl_q};
                OFF_COUNT:  rdata = count_q;
                OFF_PRESET: rdata = preset_q;
                OFF_STATUS: rdata = {31'd0, status_q};
                default:    rdata = 32'd0;
            endcase
        end
    end

    // Timer next state; CPU register writes override the timer's own updates
    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        count_d    = count_q;
        psc_d      = psc_q;
        expire_set = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q[0]) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                psc_d   = '0;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q[0]) begin
                    state_d = ST_IDLE;
                end else if (psc_q == PSC_LAST) begin
                    psc_d = '0;
                    if (count_q == 32'd0) begin
                        state_d = ST_EXPIRE;
                    end else begin
                        count_d = count_q - 32'd1;
                    end
                end else begin
                    psc_d = psc_q + PSC_W'(1);
                end
            end
            ST_EXPIRE: begin
                expire_set = 1'b1;
                if (ctrl_q[1]) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d   = ST_IDLE;
                    ctrl_d[0] = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (wr_ctrl) begin
            ctrl_d = wdata[2:0];
            if (state_q == ST_EXPIRE && !wdata[0]) begin
                state_d = ST_IDLE;
            end
        end
        if (wr_count) begin
            count_d = wdata;
        end

        // Expiry set beats a same-cycle write-1-clear
        status_d = (status_q & ~(wr_status & wdata[0])) | expire_set;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ctrl_q  <= 3'd0;
            count_q <= 32'd0;
            psc_q   <= '0;
            status_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            count_q  <= count_d;
            psc_q    <= psc_d;
            status_q <= status_d;
            irq_q    <= status_d & ctrl_d[2];
        end
    end

    // LED / PRESET registers and the two-flop switch synchronizer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q     <= 16'd0;
            preset_q  <= 32'd0;
            sw_meta_q <= 16'd0;
            sw_sync_q <= 16'd0;
        end else begin
            if (wr_led) begin
                led_q <= wdata[15:0];
            end
            if (wr_preset) begin
                preset_q <= wdata;
            end
            sw_meta_q <= sw_in;
            sw_sync_q <= sw_meta_q;
        end
    end

endmodule
